// File: rtl/fifo_check_pkg.sv
// Shared types and helpers for the fifo_check_tally compare-and-tally unit.
package fifo_check_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam int CNT_W_DEFAULT = 64;

   // Counters up to 64 bits wide; lim is the caller's all-ones value.
   function automatic logic [63:0] sat_add(input logic [63:0] cnt, input logic [63:0] inc,
                                           input logic [63:0] lim = 64'hFFFF_FFFF_FFFF_FFFF);
      logic [64:0] sum;
      sum = {1'b0, cnt} + {1'b0, inc};
      return (sum > {1'b0, lim}) ? lim : sum[63:0];
   endfunction

endpackage

// File: rtl/fifo_check_lane.sv
// One compare lane: stage-1 compare register plus saturating ok/err counters.
// With CHECK_FIRST_ERR_EN defined, the registered expected/actual data is exported.
module fifo_check_lane
   import fifo_check_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int CNT_W  = CNT_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_run,
   input  logic              i_cnt_en,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_exp,
   input  logic [DATA_W-1:0] i_act,
   output logic              o_vld_p1,
   output logic              o_match_p1,
`ifdef CHECK_FIRST_ERR_EN
   output logic [DATA_W-1:0] o_exp_p1,
   output logic [DATA_W-1:0] o_act_p1,
`endif
   output logic [CNT_W-1:0]  o_ok_cnt,
   output logic [CNT_W-1:0]  o_err_cnt
);

   localparam logic [63:0] LIM = 64'({CNT_W{1'b1}});

   logic             r_vld_p1;
   logic             r_match_p1;
   logic [CNT_W-1:0] r_ok_cnt;
   logic [CNT_W-1:0] r_err_cnt;

   // Stage 1: register the compare; samples outside RUN never enter the pipe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_p1   <= 1'b0;
         r_match_p1 <= 1'b0;
      end else if (i_clr) begin
         r_vld_p1   <= 1'b0;
         r_match_p1 <= 1'b0;
      end else begin
         r_vld_p1   <= i_run & i_valid;
         r_match_p1 <= (i_exp == i_act);
      end
   end

`ifdef CHECK_FIRST_ERR_EN
   logic [DATA_W-1:0] r_exp_p1;
   logic [DATA_W-1:0] r_act_p1;

   always_ff @(posedge clk) begin
      r_exp_p1 <= i_exp;
      r_act_p1 <= i_act;
   end

   assign o_exp_p1 = r_exp_p1;
   assign o_act_p1 = r_act_p1;
`endif

   // Stage 2: retire into the saturating counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ok_cnt  <= '0;
         r_err_cnt <= '0;
      end else if (i_clr) begin
         r_ok_cnt  <= '0;
         r_err_cnt <= '0;
      end else if (i_cnt_en && r_vld_p1) begin
         if (r_match_p1)
            r_ok_cnt  <= CNT_W'(sat_add(64'(r_ok_cnt), 64'd1, LIM));
         else
            r_err_cnt <= CNT_W'(sat_add(64'(r_err_cnt), 64'd1, LIM));
      end
   end

   assign o_vld_p1   = r_vld_p1;
   assign o_match_p1 = r_match_p1;
   assign o_ok_cnt   = r_ok_cnt;
   assign o_err_cnt  = r_err_cnt;

endmodule

// File: rtl/fifo_check_tally.sv
// Multi-lane compare-and-tally with run/drain/done window and saturating counters.
// Optional first-mismatch capture is built when CHECK_FIRST_ERR_EN is defined.
module fifo_check_tally
   import fifo_check_pkg::*;
#(
   parameter  int CH_NUM = 4,
   parameter  int DATA_W = 16,
   parameter  int CNT_W  = CNT_W_DEFAULT,
   localparam int SEL_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop_req,
   input  logic [CH_NUM-1:0]        chk_valid,
   input  logic [CH_NUM*DATA_W-1:0] chk_expected,
   input  logic [CH_NUM*DATA_W-1:0] chk_actual,
   input  logic [SEL_W-1:0]         rd_sel,
   output logic [CNT_W-1:0]         rd_ok_cnt,
   output logic [CNT_W-1:0]         rd_err_cnt,
   output logic [CNT_W-1:0]         total_ok_cnt,
   output logic [CNT_W-1:0]         total_err_cnt,
`ifdef CHECK_FIRST_ERR_EN
   output logic                     first_err_vld,
   output logic [SEL_W-1:0]         first_err_ch,
   output logic [DATA_W-1:0]        first_err_exp,
   output logic [DATA_W-1:0]        first_err_act,
`endif
   output logic                     busy,
   output logic                     test_finished,
   output logic                     any_error
);

   localparam int          INC_W = $clog2(CH_NUM + 1);
   localparam logic [63:0] LIM   = 64'({CNT_W{1'b1}});

   state_t            r_state, w_state_nxt;
   logic              w_run, w_cnt_en;
   logic [CH_NUM-1:0] w_vld_p1, w_match_p1;
   logic [CNT_W-1:0]  w_ok_cnt  [CH_NUM];
   logic [CNT_W-1:0]  w_err_cnt [CH_NUM];
   logic [INC_W-1:0]  w_ok_inc, w_err_inc;
   logic [CNT_W-1:0]  r_tot_ok, r_tot_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (start) begin
         w_state_nxt = RUN;
      end else begin
         case (r_state)
            RUN:     if (stop_req) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = DONE;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   assign w_run         = (r_state == RUN);
   assign w_cnt_en      = (r_state == RUN) || (r_state == DRAIN);
   assign busy          = w_cnt_en;
   assign test_finished = (r_state == DONE);

`ifdef CHECK_FIRST_ERR_EN
   logic [DATA_W-1:0] w_exp_p1 [CH_NUM];
   logic [DATA_W-1:0] w_act_p1 [CH_NUM];
`endif

   for (genvar g = 0; g < CH_NUM; g++) begin : g_lane
      fifo_check_lane #(
         .DATA_W (DATA_W),
         .CNT_W  (CNT_W)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .i_clr      (start),
         .i_run      (w_run),
         .i_cnt_en   (w_cnt_en),
         .i_valid    (chk_valid[g]),
         .i_exp      (chk_expected[g*DATA_W +: DATA_W]),
         .i_act      (chk_actual[g*DATA_W +: DATA_W]),
         .o_vld_p1   (w_vld_p1[g]),
         .o_match_p1 (w_match_p1[g]),
`ifdef CHECK_FIRST_ERR_EN
         .o_exp_p1   (w_exp_p1[g]),
         .o_act_p1   (w_act_p1[g]),
`endif
         .o_ok_cnt   (w_ok_cnt[g]),
         .o_err_cnt  (w_err_cnt[g])
      );
   end

   always_comb begin
      w_ok_inc  = '0;
      w_err_inc = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         w_ok_inc  = w_ok_inc  + INC_W'(w_vld_p1[i] &  w_match_p1[i]);
         w_err_inc = w_err_inc + INC_W'(w_vld_p1[i] & ~w_match_p1[i]);
      end
   end

   // Stage 2: totals saturate on their own, independent of the lane counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tot_ok  <= '0;
         r_tot_err <= '0;
      end else if (start) begin
         r_tot_ok  <= '0;
         r_tot_err <= '0;
      end else if (w_cnt_en) begin
         r_tot_ok  <= CNT_W'(sat_add(64'(r_tot_ok),  64'(w_ok_inc),  LIM));
         r_tot_err <= CNT_W'(sat_add(64'(r_tot_err), 64'(w_err_inc), LIM));
      end
   end

   assign total_ok_cnt  = r_tot_ok;
   assign total_err_cnt = r_tot_err;
   assign any_error     = (r_tot_err != '0);

   // Unmatched selects fall through to zero.
   always_comb begin
      rd_ok_cnt  = '0;
      rd_err_cnt = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (rd_sel == SEL_W'(i)) begin
            rd_ok_cnt  = w_ok_cnt[i];
            rd_err_cnt = w_err_cnt[i];
         end
      end
   end

`ifdef CHECK_FIRST_ERR_EN
   logic              w_mis_any;
   logic [SEL_W-1:0]  w_mis_ch;
   logic [DATA_W-1:0] w_mis_exp, w_mis_act;
   logic              r_fe_vld;
   logic [SEL_W-1:0]  r_fe_ch;
   logic [DATA_W-1:0] r_fe_exp, r_fe_act;

   // Descending scan so the lowest mismatching lane is the one left selected.
   always_comb begin
      w_mis_any = 1'b0;
      w_mis_ch  = '0;
      w_mis_exp = '0;
      w_mis_act = '0;
      for (int i = CH_NUM - 1; i >= 0; i--) begin
         if (w_vld_p1[i] && !w_match_p1[i]) begin
            w_mis_any = 1'b1;
            w_mis_ch  = SEL_W'(i);
            w_mis_exp = w_exp_p1[i];
            w_mis_act = w_act_p1[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fe_vld <= 1'b0;
         r_fe_ch  <= '0;
         r_fe_exp <= '0;
         r_fe_act <= '0;
      end else if (start) begin
         r_fe_vld <= 1'b0;
      end else if (w_cnt_en && w_mis_any && !r_fe_vld) begin
         r_fe_vld <= 1'b1;
         r_fe_ch  <= w_mis_ch;
         r_fe_exp <= w_mis_exp;
         r_fe_act <= w_mis_act;
      end
   end

   assign first_err_vld = r_fe_vld;
   assign first_err_ch  = r_fe_ch;
   assign first_err_exp = r_fe_exp;
   assign first_err_act = r_fe_act;
`endif

endmodule

// File: tb/tb_fifo_check_tally.sv
// Bench for fifo_check_tally: a 4-lane 64-bit instance and a 3-lane 4-bit instance
// share stimulus and are checked against an exact-count reference model.
`timescale 1ns/1ps
module tb_fifo_check_tally;

   logic        clk = 1'b0;
   logic        rst, start, stop_req;
   logic [3:0]  chk_valid;
   logic [63:0] chk_expected, chk_actual;
   logic [1:0]  rd_sel;
   logic [63:0] ok_m, err_m, tok_m, terr_m;
   logic        busy_m, fin_m, anyerr_m;
   logic [3:0]  ok_s, err_s, tok_s, terr_s;
   logic        busy_s, fin_s, anyerr_s;
`ifdef CHECK_FIRST_ERR_EN
   logic        fe_vld_m, fe_vld_s;
   logic [1:0]  fe_ch_m, fe_ch_s;
   logic [15:0] fe_exp_m, fe_act_m, fe_exp_s, fe_act_s;
`endif

   always #5 clk = ~clk;

   fifo_check_tally #(.CH_NUM(4), .DATA_W(16), .CNT_W(64)) u_dut (
      .clk(clk), .rst(rst), .start(start), .stop_req(stop_req),
      .chk_valid(chk_valid), .chk_expected(chk_expected), .chk_actual(chk_actual),
      .rd_sel(rd_sel), .rd_ok_cnt(ok_m), .rd_err_cnt(err_m),
      .total_ok_cnt(tok_m), .total_err_cnt(terr_m),
`ifdef CHECK_FIRST_ERR_EN
      .first_err_vld(fe_vld_m), .first_err_ch(fe_ch_m),
      .first_err_exp(fe_exp_m), .first_err_act(fe_act_m),
`endif
      .busy(busy_m), .test_finished(fin_m), .any_error(anyerr_m)
   );

   fifo_check_tally #(.CH_NUM(3), .DATA_W(16), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .start(start), .stop_req(stop_req),
      .chk_valid(chk_valid[2:0]), .chk_expected(chk_expected[47:0]), .chk_actual(chk_actual[47:0]),
      .rd_sel(rd_sel), .rd_ok_cnt(ok_s), .rd_err_cnt(err_s),
      .total_ok_cnt(tok_s), .total_err_cnt(terr_s),
`ifdef CHECK_FIRST_ERR_EN
      .first_err_vld(fe_vld_s), .first_err_ch(fe_ch_s),
      .first_err_exp(fe_exp_s), .first_err_act(fe_act_s),
`endif
      .busy(busy_s), .test_finished(fin_s), .any_error(anyerr_s)
   );

   // Reference model: exact per-lane counts, window phase, one cycle of in-flight samples.
   longint     m_ok [4];
   longint     m_err[4];
   logic [3:0] p_vld, p_mat;
   int         m_ph;      // 0 idle, 1 run, 2 drain, 3 done
   int         n_chk = 0;
   int         n_fail = 0;

   function automatic longint sat4(input longint x);
      return (x > 15) ? 64'd15 : x;
   endfunction

   function automatic longint sum_ok(input int n);
      longint s = 0;
      for (int l = 0; l < n; l++) s += m_ok[l];
      return s;
   endfunction

   function automatic longint sum_err(input int n);
      longint s = 0;
      for (int l = 0; l < n; l++) s += m_err[l];
      return s;
   endfunction

   task automatic model_reset();
      for (int l = 0; l < 4; l++) begin
         m_ok[l]  = 0;
         m_err[l] = 0;
      end
      p_vld = '0;
      p_mat = '0;
      m_ph  = 0;
   endtask

   // Drive one cycle of stimulus (mis marks lanes whose actual differs), advance the model.
   task automatic step(input logic st, input logic sp, input logic [3:0] v, input logic [3:0] mis);
      logic [63:0] e, a;
      int          old;
      for (int l = 0; l < 4; l++) begin
         e[16*l +: 16] = 16'($urandom);
         a[16*l +: 16] = mis[l] ? (e[16*l +: 16] ^ (16'd1 << $urandom_range(15))) : e[16*l +: 16];
      end
      start = st; stop_req = sp; chk_valid = v; chk_expected = e; chk_actual = a;
      @(posedge clk);
      old = m_ph;
      if (st) begin
         for (int l = 0; l < 4; l++) begin
            m_ok[l]  = 0;
            m_err[l] = 0;
         end
         p_vld = '0;
         m_ph  = 1;
      end else begin
         if (old == 1 || old == 2)
            for (int l = 0; l < 4; l++)
               if (p_vld[l]) begin
                  if (p_mat[l]) m_ok[l]++;
                  else          m_err[l]++;
               end
         p_vld = (old == 1) ? v : 4'b0;
         p_mat = ~mis;
         if (old == 1 && sp) m_ph = 2;
         else if (old == 2)  m_ph = 3;
      end
      #1;
      start = 1'b0; stop_req = 1'b0; chk_valid = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; stop_req = 1'b0; chk_valid = '0;
      chk_expected = '0; chk_actual = '0; rd_sel = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      for (int l = 0; l < 4; l++) begin
         rd_sel = 2'(l);
         #1;
         n_chk++;
         if ({ok_m, err_m, ok_s, err_s} !== '0) begin
            n_fail++;
            $display("FAIL reset_lane%0d got ok=%0d err=%0d sat ok=%0d err=%0d, want all 0", l, ok_m, err_m, ok_s, err_s);
         end
      end
      n_chk++;
      if ({tok_m, terr_m, tok_s, terr_s, busy_m, fin_m, anyerr_m, busy_s, fin_s, anyerr_s} !== '0) begin
         n_fail++;
         $display("FAIL reset_status got tok=%0d terr=%0d busy=%b fin=%b anyerr=%b, want 0", tok_m, terr_m, busy_m, fin_m, anyerr_m);
      end
      step(1'b0, 1'b1, 4'hF, 4'h3);
      step(1'b0, 1'b0, 4'hF, 4'h0);
      step(1'b0, 1'b0, 4'h0, 4'h0);
      n_chk++;
      if ({busy_m, fin_m, tok_m, terr_m} !== '0) begin
         n_fail++;
         $display("FAIL idle_ignores got busy=%b fin=%b tok=%0d terr=%0d, want 0", busy_m, fin_m, tok_m, terr_m);
      end
   endtask

   task automatic test_lane0_match();
      rd_sel = 2'd0;
      step(1'b1, 1'b0, 4'h0, 4'h0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'b0001, 4'h0);
      step(1'b0, 1'b1, 4'h0, 4'h0);
      n_chk++;
      if ({busy_m, fin_m} !== 2'b10) begin
         n_fail++;
         $display("FAIL drain_flags got busy=%b fin=%b, want busy=1 fin=0", busy_m, fin_m);
      end
      step(1'b0, 1'b0, 4'h0, 4'h0);
      n_chk++;
      if ({busy_m, fin_m, anyerr_m} !== 3'b010) begin
         n_fail++;
         $display("FAIL done_flags got busy=%b fin=%b anyerr=%b, want 0 1 0", busy_m, fin_m, anyerr_m);
      end
      n_chk++;
      if (ok_m !== 64'd10 || err_m !== 64'd0 || tok_m !== 64'd10 || ok_s !== 4'd10) begin
         n_fail++;
         $display("FAIL lane0_counts got ok=%0d err=%0d tok=%0d sat_ok=%0d, want 10 0 10 10", ok_m, err_m, tok_m, ok_s);
      end
   endtask

   task automatic test_mixed_lanes();
      step(1'b1, 1'b0, 4'h0, 4'h0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'b1010, (i == 1 || i == 3) ? 4'b1000 : 4'b0000);
      step(1'b0, 1'b1, 4'h0, 4'h0);
      step(1'b0, 1'b0, 4'h0, 4'h0);
      rd_sel = 2'd1;
      #1;
      n_chk++;
      if (ok_m !== 64'd5 || err_m !== 64'd0 || ok_s !== 4'd5) begin
         n_fail++;
         $display("FAIL mixed_lane1 got ok=%0d err=%0d sat_ok=%0d, want 5 0 5", ok_m, err_m, ok_s);
      end
      rd_sel = 2'd3;
      #1;
      n_chk++;
      if (ok_m !== 64'd3 || err_m !== 64'd2) begin
         n_fail++;
         $display("FAIL mixed_lane3 got ok=%0d err=%0d, want 3 2", ok_m, err_m);
      end
      n_chk++;
      if (tok_m !== 64'd8 || terr_m !== 64'd2 || anyerr_m !== 1'b1) begin
         n_fail++;
         $display("FAIL mixed_totals got tok=%0d terr=%0d anyerr=%b, want 8 2 1", tok_m, terr_m, anyerr_m);
      end
      n_chk++;
      if (tok_s !== 4'd5 || terr_s !== 4'd0 || anyerr_s !== 1'b0 || ok_s !== 4'd0) begin
         n_fail++;
         $display("FAIL mixed_sat got tok=%0d terr=%0d anyerr=%b oob_ok=%0d, want 5 0 0 0", tok_s, terr_s, anyerr_s, ok_s);
      end
   endtask

   task automatic test_saturation();
      step(1'b1, 1'b0, 4'h0, 4'h0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 4'b0100, 4'h0);
      step(1'b0, 1'b1, 4'h0, 4'h0);
      step(1'b0, 1'b0, 4'h0, 4'h0);
      rd_sel = 2'd2;
      #1;
      n_chk++;
      if (ok_s !== 4'd15 || tok_s !== 4'd15 || err_s !== 4'd0) begin
         n_fail++;
         $display("FAIL sat_lane2 got ok=%0d tok=%0d err=%0d, want 15 15 0", ok_s, tok_s, err_s);
      end
      n_chk++;
      if (ok_m !== 64'd20 || tok_m !== 64'd20) begin
         n_fail++;
         $display("FAIL wide_lane2 got ok=%0d tok=%0d, want 20 20", ok_m, tok_m);
      end
   endtask

   task automatic test_boundary();
      step(1'b1, 1'b0, 4'h0, 4'h0);
      step(1'b0, 1'b1, 4'b0001, 4'h0);
      step(1'b0, 1'b0, 4'b0010, 4'h0);
      step(1'b0, 1'b0, 4'b0100, 4'h0);
      step(1'b0, 1'b0, 4'h0, 4'h0);
      rd_sel = 2'd0;
      #1;
      n_chk++;
      if (ok_m !== 64'd1 || tok_m !== 64'd1 || tok_s !== 4'd1 || fin_m !== 1'b1) begin
         n_fail++;
         $display("FAIL window_edges got ok0=%0d tok=%0d tok_s=%0d fin=%b, want 1 1 1 1", ok_m, tok_m, tok_s, fin_m);
      end
      rd_sel = 2'd3;
      #1;
      n_chk++;
      if ({ok_s, err_s} !== 8'h00) begin
         n_fail++;
         $display("FAIL oob_readout got ok=%0d err=%0d, want 0 0", ok_s, err_s);
      end
      step(1'b1, 1'b1, 4'b0001, 4'h0);
      n_chk++;
      if ({busy_m, fin_m} !== 2'b10 || tok_m !== 64'd0) begin
         n_fail++;
         $display("FAIL start_stop got busy=%b fin=%b tok=%0d, want 1 0 0", busy_m, fin_m, tok_m);
      end
      step(1'b0, 1'b0, 4'b0001, 4'h0);
      n_chk++;
      if (tok_m !== 64'd0) begin
         n_fail++;
         $display("FAIL latency_early got tok=%0d, want 0", tok_m);
      end
      step(1'b0, 1'b0, 4'h0, 4'h0);
      n_chk++;
      if (tok_m !== 64'd1 || busy_m !== 1'b1) begin
         n_fail++;
         $display("FAIL latency_k2 got tok=%0d busy=%b, want 1 1", tok_m, busy_m);
      end
   endtask

   task automatic test_reset_mid_run();
      rd_sel = 2'd0;
      step(1'b1, 1'b0, 4'h0, 4'h0);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 4'b0001, 4'h0);
      step(1'b0, 1'b0, 4'h0, 4'h0);
      n_chk++;
      if (ok_m !== 64'd7) begin
         n_fail++;
         $display("FAIL pre_reset got ok=%0d, want 7", ok_m);
      end
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if ({ok_m, tok_m, ok_s, tok_s, busy_m, fin_m, busy_s} !== '0) begin
         n_fail++;
         $display("FAIL async_reset got ok=%0d tok=%0d busy=%b fin=%b, want 0", ok_m, tok_m, busy_m, fin_m);
      end
      #1 rst = 1'b0;
      model_reset();
      step(1'b1, 1'b0, 4'h0, 4'h0);
      step(1'b0, 1'b0, 4'b0001, 4'h0);
      step(1'b0, 1'b0, 4'h0, 4'h0);
      n_chk++;
      if (ok_m !== 64'd1 || tok_m !== 64'd1) begin
         n_fail++;
         $display("FAIL restart_count got ok=%0d tok=%0d, want 1 1", ok_m, tok_m);
      end
   endtask

   task automatic test_random();
      int         r;
      logic [7:0] exp_s;
      for (int c = 0; c < 400; c++) begin
         r = $urandom_range(99);
         step(r < 3, r >= 3 && r < 8, 4'($urandom), 4'($urandom) & 4'($urandom));
         rd_sel = 2'($urandom);
         #1;
         n_chk++;
         if ({ok_m, err_m} !== {64'(m_ok[rd_sel]), 64'(m_err[rd_sel])}) begin
            n_fail++;
            $display("FAIL rnd_lane%0d cyc%0d got %0d/%0d, want %0d/%0d", rd_sel, c, ok_m, err_m, m_ok[rd_sel], m_err[rd_sel]);
         end
         exp_s = (rd_sel < 2'd3) ? {4'(sat4(m_ok[rd_sel])), 4'(sat4(m_err[rd_sel]))} : 8'h00;
         n_chk++;
         if ({ok_s, err_s} !== exp_s) begin
            n_fail++;
            $display("FAIL rnd_sat_lane%0d cyc%0d got %0d/%0d, want %0d/%0d", rd_sel, c, ok_s, err_s, exp_s[7:4], exp_s[3:0]);
         end
         n_chk++;
         if ({tok_m, terr_m} !== {64'(sum_ok(4)), 64'(sum_err(4))}) begin
            n_fail++;
            $display("FAIL rnd_totals cyc%0d got %0d/%0d, want %0d/%0d", c, tok_m, terr_m, sum_ok(4), sum_err(4));
         end
         n_chk++;
         if ({tok_s, terr_s} !== {4'(sat4(sum_ok(3))), 4'(sat4(sum_err(3)))}) begin
            n_fail++;
            $display("FAIL rnd_sat_totals cyc%0d got %0d/%0d, want %0d/%0d", c, tok_s, terr_s, sat4(sum_ok(3)), sat4(sum_err(3)));
         end
         n_chk++;
         if ({busy_m, fin_m, anyerr_m, busy_s, fin_s, anyerr_s} !==
             {m_ph == 1 || m_ph == 2, m_ph == 3, sum_err(4) != 0, m_ph == 1 || m_ph == 2, m_ph == 3, sum_err(3) != 0}) begin
            n_fail++;
            $display("FAIL rnd_flags cyc%0d got %b%b%b %b%b%b, phase %0d", c, busy_m, fin_m, anyerr_m, busy_s, fin_s, anyerr_s, m_ph);
         end
      end
   endtask

`ifdef CHECK_FIRST_ERR_EN
   task automatic test_first_err();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk_valid    = 4'b0110;
      chk_expected = {16'h0000, 16'h1234, 16'hA5A5, 16'h0000};
      chk_actual   = {16'h0000, 16'h0234, 16'h0000, 16'h0000};
      @(posedge clk);
      #1 chk_valid = 4'b0000;
      n_chk++;
      if (fe_vld_m !== 1'b0) begin
         n_fail++;
         $display("FAIL fe_early got vld=%b, want 0", fe_vld_m);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if ({fe_vld_m, fe_ch_m, fe_exp_m, fe_act_m} !== {1'b1, 2'd1, 16'hA5A5, 16'h0000}) begin
         n_fail++;
         $display("FAIL fe_capture got vld=%b ch=%0d exp=%h act=%h, want 1 1 a5a5 0000", fe_vld_m, fe_ch_m, fe_exp_m, fe_act_m);
      end
      chk_valid    = 4'b0001;
      chk_expected = {48'h0, 16'h1111};
      chk_actual   = {48'h0, 16'h2222};
      @(posedge clk);
      #1 chk_valid = 4'b0000;
      @(posedge clk);
      #1;
      n_chk++;
      if ({fe_vld_m, fe_ch_m, fe_exp_m, fe_act_m, fe_ch_s} !== {1'b1, 2'd1, 16'hA5A5, 16'h0000, 2'd1}) begin
         n_fail++;
         $display("FAIL fe_sticky got vld=%b ch=%0d exp=%h act=%h sat_ch=%0d", fe_vld_m, fe_ch_m, fe_exp_m, fe_act_m, fe_ch_s);
      end
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n_chk++;
      if ({fe_vld_m, fe_vld_s} !== 2'b00) begin
         n_fail++;
         $display("FAIL fe_clear got vld=%b/%b, want 0", fe_vld_m, fe_vld_s);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lane0_match();
      test_mixed_lanes();
      test_saturation();
      test_boundary();
      test_reset_mid_run();
      test_random();
`ifdef CHECK_FIRST_ERR_EN
      test_first_err();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
